// File: rtl/rf_wport_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter: default sizes
// and the port-select encoding used by the arbitration logic.
package rf_wport_arbiter_pkg;

  localparam int WIDTH_DEF      = 32;
  localparam int DEPTH_BITS_DEF = 5;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_e;

endpackage

// File: rtl/rf_wport_holdbuf.sv
// One-entry hold buffer for a register-file write request. It accepts a new
// request while empty or while its current entry is being granted away.
module rf_wport_holdbuf
  import rf_wport_arbiter_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int DEPTH_BITS = DEPTH_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic [DEPTH_BITS-1:0] addr,
  input  logic [WIDTH-1:0]      data,
  input  logic                  grant,
  input  logic                  flush,
  output logic                  ready,
  output logic                  held,
  output logic [DEPTH_BITS-1:0] held_addr,
  output logic [WIDTH-1:0]      held_data
);

  logic capture;

  assign ready   = !flush && (!held || grant);
  // Writes to register 0 are handshaken normally but never stored.
  assign capture = valid && ready && (addr != '0);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held      <= 1'b0;
      held_addr <= '0;
      held_data <= '0;
    end else if (capture) begin
      held      <= 1'b1;
      held_addr <= addr;
      held_data <= data;
    end else if (grant || flush) begin
      held      <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Two-port register-file write arbiter: per-port hold buffers, round-robin
// grant with same-address ordering, a registered write port and a busy map.
module rf_wport_arbiter
  import rf_wport_arbiter_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int DEPTH_BITS = DEPTH_BITS_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [DEPTH_BITS-1:0]      a_addr,
  input  logic [WIDTH-1:0]           a_data,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic [DEPTH_BITS-1:0]      b_addr,
  input  logic [WIDTH-1:0]           b_data,
  input  logic                       a_flush,
  output logic                       WrEn,
  output logic [DEPTH_BITS-1:0]      WrAddress,
  output logic [WIDTH-1:0]           WrData,
  output logic [(1<<DEPTH_BITS)-1:0] busy
);

  logic                  held_a, held_b;
  logic [DEPTH_BITS-1:0] haddr_a, haddr_b;
  logic [WIDTH-1:0]      hdata_a, hdata_b;
  logic                  req_a, req_b;
  logic                  grant_a, grant_b;
  logic                  b_won_prev;
  port_sel_e             last_grant;

  rf_wport_holdbuf #(.WIDTH(WIDTH), .DEPTH_BITS(DEPTH_BITS)) u_buf_a (
    .clk       (clk),
    .rst       (rst),
    .valid     (a_valid),
    .addr      (a_addr),
    .data      (a_data),
    .grant     (grant_a),
    .flush     (a_flush),
    .ready     (a_ready),
    .held      (held_a),
    .held_addr (haddr_a),
    .held_data (hdata_a)
  );

  rf_wport_holdbuf #(.WIDTH(WIDTH), .DEPTH_BITS(DEPTH_BITS)) u_buf_b (
    .clk       (clk),
    .rst       (rst),
    .valid     (b_valid),
    .addr      (b_addr),
    .data      (b_data),
    .grant     (grant_b),
    .flush     (1'b0),
    .ready     (b_ready),
    .held      (held_b),
    .held_addr (haddr_b),
    .held_data (hdata_b)
  );

  assign req_a = held_a && !a_flush;
  assign req_b = held_b;

  // On an address tie B goes first so A's value lands last; if B already won
  // the previous cycle, A is served now so it never waits more than one cycle.
  // NOTE: every output of this block gets a default first, so no path through
  // the if/else leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (req_a && req_b) begin
      if (haddr_a == haddr_b) begin
        grant_a = b_won_prev;
        grant_b = !b_won_prev;
      end else if (last_grant == PORT_B) begin
        grant_a = 1'b1;
      end else begin
        grant_b = 1'b1;
      end
    end else begin
      grant_a = req_a;
      grant_b = req_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WrEn       <= 1'b0;
      WrAddress  <= '0;
      WrData     <= '0;
      last_grant <= PORT_B;
      b_won_prev <= 1'b0;
    end else begin
      WrEn       <= grant_a || grant_b;
      b_won_prev <= grant_b;
      if (grant_b) begin
        WrAddress  <= haddr_b;
        WrData     <= hdata_b;
        last_grant <= PORT_B;
      end else if (grant_a) begin
        WrAddress  <= haddr_a;
        WrData     <= hdata_a;
        last_grant <= PORT_A;
      end
    end
  end

  always_comb begin
    busy = '0;
    if (held_a) busy[haddr_a]   = 1'b1;
    if (held_b) busy[haddr_b]   = 1'b1;
    if (WrEn)   busy[WrAddress] = 1'b1;
    busy[0] = 1'b0;
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Self-checking bench for rf_wport_arbiter: directed scenarios with literal
// expectations, then randomized traffic compared every cycle to a port model.
module tb_rf_wport_arbiter;

  localparam int W  = 32;
  localparam int DB = 5;
  localparam int NR = 1 << DB;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, b_valid, a_flush;
  logic [DB-1:0] a_addr, b_addr;
  logic [W-1:0]  a_data, b_data;
  logic          a_ready, b_ready;
  logic          WrEn;
  logic [DB-1:0] WrAddress;
  logic [W-1:0]  WrData;
  logic [NR-1:0] busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  rf_wport_arbiter #(.WIDTH(W), .DEPTH_BITS(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .a_flush   (a_flush),
    .WrEn      (WrEn),
    .WrAddress (WrAddress),
    .WrData    (WrData),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: ports indexed 0 = A, 1 = B ----------
  typedef struct {
    bit            held;
    logic [DB-1:0] addr;
    logic [W-1:0]  data;
  } entry_t;

  entry_t        mb[2];
  int            m_last;    // port granted most recently
  bit            m_bprev;   // B was granted in the previous cycle
  bit            m_wen;
  logic [DB-1:0] m_waddr;
  logic [W-1:0]  m_wdata;
  int            m_w;
  bit            m_ra, m_rb;

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      mb[p].held = 1'b0;
      mb[p].addr = '0;
      mb[p].data = '0;
    end
    m_last  = 1;
    m_bprev = 1'b0;
    m_wen   = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
  endtask

  // Winner this cycle: -1 none, 0 A, 1 B.
  function automatic int model_win();
    bit ca, cb;
    ca = mb[0].held && !a_flush;
    cb = mb[1].held;
    if (ca && cb) begin
      if (mb[0].addr == mb[1].addr) return m_bprev ? 0 : 1;
      return (m_last == 1) ? 0 : 1;
    end
    if (ca) return 0;
    if (cb) return 1;
    return -1;
  endfunction

  function automatic bit model_ready(input int p);
    int w;
    w = model_win();
    if (p == 0) return !a_flush && (!mb[0].held || w == 0);
    return !mb[1].held || w == 1;
  endfunction

  function automatic logic [NR-1:0] model_busy();
    logic [NR-1:0] b;
    b = '0;
    for (int p = 0; p < 2; p++) if (mb[p].held) b[mb[p].addr] = 1'b1;
    if (m_wen) b[m_waddr] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_reset();
      end else begin
        m_w  = model_win();
        m_ra = model_ready(0);
        m_rb = model_ready(1);
        m_wen = (m_w >= 0);
        if (m_w >= 0) begin
          m_waddr = mb[m_w].addr;
          m_wdata = mb[m_w].data;
          m_last  = m_w;
        end
        m_bprev = (m_w == 1);
        if (a_valid && m_ra && a_addr != 0) begin
          mb[0].held = 1'b1; mb[0].addr = a_addr; mb[0].data = a_data;
        end else if (m_w == 0 || a_flush) begin
          mb[0].held = 1'b0;
        end
        if (b_valid && m_rb && b_addr != 0) begin
          mb[1].held = 1'b1; mb[1].addr = b_addr; mb[1].data = b_data;
        end else if (m_w == 1) begin
          mb[1].held = 1'b0;
        end
      end
    end
  end

  // Compare process: mid-cycle, when inputs and outputs are both settled.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("a_ready",   a_ready,   model_ready(0));
        check("b_ready",   b_ready,   model_ready(1));
        check("WrEn",      WrEn,      m_wen);
        check("WrAddress", WrAddress, m_waddr);
        check("WrData",    WrData,    m_wdata);
        check("busy",      busy,      model_busy());
      end
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 1'b0; b_valid = 1'b0; a_flush = 1'b0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step();
    chk_en = 1'b1;
    check("rst_wren",  WrEn, 1'b0);
    check("rst_waddr", WrAddress, 0);
    check("rst_wdata", WrData, 0);
    check("rst_busy",  busy, 0);
    check("rst_ready", {a_ready, b_ready}, 2'b11);
    step();
    rst = 1'b0;

    // Single write: visible only after the second edge.
    do_reset();
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
    step();
    a_valid = 1'b0;
    check("single_en_e1", WrEn, 1'b0);
    check("single_busy_e1", busy, 32'h0000_0020);
    step();
    check("single_en_e2", WrEn, 1'b1);
    check("single_addr_e2", WrAddress, 5);
    check("single_data_e2", WrData, 32'hDEADBEEF);
    check("single_busy_e2", busy, 32'h0000_0020);
    step();
    check("single_en_e3", WrEn, 1'b0);
    check("single_busy_e3", busy, 0);
    check("single_hold_addr", WrAddress, 5);

    // Contention: A first after reset, then B.
    do_reset();
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h11;
    b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h22;
    step();
    idle();
    step();
    check("cont_first", {WrEn, WrAddress, WrData}, {1'b1, 5'd3, 32'h11});
    step();
    check("cont_second", {WrEn, WrAddress, WrData}, {1'b1, 5'd4, 32'h22});
    step();
    check("cont_done", WrEn, 1'b0);

    // Continuous streaming from both ports alternates A, B, A, B.
    do_reset();
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h11;
    b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h22;
    step();
    for (int k = 0; k < 6; k++) begin
      step();
      check("stream_en", WrEn, 1'b1);
      check("stream_addr", WrAddress, (k % 2 == 0) ? 5'd3 : 5'd4);
    end
    idle();
    repeat (4) step();

    // Same address: B's value first, A's value last.
    do_reset();
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'hAA;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'hBB;
    step();
    idle();
    step();
    check("same_first", {WrEn, WrAddress, WrData}, {1'b1, 5'd7, 32'hBB});
    step();
    check("same_second", {WrEn, WrAddress, WrData}, {1'b1, 5'd7, 32'hAA});
    step();

    // Register 0 is handshaken and dropped.
    do_reset();
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h1234;
    #1;
    check("x0_ready", b_ready, 1'b1);
    step();
    idle();
    check("x0_en_e1", WrEn, 1'b0);
    check("x0_busy_e1", busy, 0);
    step();
    check("x0_en_e2", WrEn, 1'b0);
    check("x0_busy_e2", busy, 0);

    // Flush discards held A while a concurrent B still gets written.
    do_reset();
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h55;
    step();
    a_valid = 1'b0; a_flush = 1'b1;
    b_valid = 1'b1; b_addr = 5'd10; b_data = 32'h66;
    #1;
    check("flush_a_ready", a_ready, 1'b0);
    check("flush_busy_held", busy[9], 1'b1);
    step();
    idle();
    check("flush_en_e2", WrEn, 1'b0);
    check("flush_busy9", busy[9], 1'b0);
    step();
    check("flush_b_write", {WrEn, WrAddress, WrData}, {1'b1, 5'd10, 32'h66});
    step();
    check("flush_no_more", WrEn, 1'b0);

    // Reset mid-stream drops everything in flight.
    do_reset();
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h1;
    b_valid = 1'b1; b_addr = 5'd6; b_data = 32'h2;
    step();
    idle();
    step();
    check("mid_pre_en", WrEn, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_en", WrEn, 1'b0);
    check("mid_rst_busy", busy, 0);
    step();
    rst = 1'b0;
    #1;
    check("mid_ready", {a_ready, b_ready}, 2'b11);
    step();
    check("mid_after1", WrEn, 1'b0);
    step();
    check("mid_after2", WrEn, 1'b0);

    // Randomized traffic, checked every cycle by the compare process.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 249) == 0);
      a_valid = ($urandom_range(0, 3) != 0);
      b_valid = ($urandom_range(0, 3) != 0);
      a_flush = ($urandom_range(0, 9) == 0);
      a_addr  = ($urandom_range(0, 3) == 0) ? DB'($urandom_range(0, NR-1)) : DB'($urandom_range(0, 5));
      b_addr  = ($urandom_range(0, 3) == 0) ? DB'($urandom_range(0, NR-1)) : DB'($urandom_range(0, 5));
      a_data  = $urandom;
      b_data  = $urandom;
      step();
    end
    rst = 1'b0;
    idle();
    repeat (6) step();
    check("drain_en", WrEn, 1'b0);
    check("drain_busy", busy, 0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
